// File: rtl/alarm_pkg.sv
// Shared widths, moduli and the per-channel alarm state encoding.
// The snooze state exists only when ALARM_SNOOZE_EN is defined.
package alarm_pkg;
  localparam int HOURS_W   = 5;
  localparam int MINS_W    = 6;
  localparam int HOURS_MOD = 24;
  localparam int MINS_MOD  = 60;

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1
  } alarm_state_e;
`endif
endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, match edge detector, ring/snooze FSM and timers.
// Snooze handling is compiled in only with ALARM_SNOOZE_EN.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_sec_tick,
  input  logic [HOURS_W-1:0] i_cur_hours,
  input  logic [MINS_W-1:0]  i_cur_minutes,
  input  logic               i_hr_en,
  input  logic               i_min_en,
  input  logic               i_up,
  input  logic               i_alarm_en,
  input  logic               i_dismiss,
  input  logic               i_snooze,
  output logic [HOURS_W-1:0] o_hours,
  output logic [MINS_W-1:0]  o_minutes,
  output logic               o_ring
);
  localparam int RT_W = $clog2(RING_SECS + 1);

  logic [HOURS_W-1:0] w_hours;
  logic [MINS_W-1:0]  w_minutes;
  logic               w_match;
  logic               r_match_q;
  alarm_state_e       r_state, w_state_nxt;
  logic [RT_W-1:0]    r_ring_timer, w_ring_timer_nxt;

  binaryCounter #(.WIDTH(HOURS_W), .MOD(HOURS_MOD)) u_hours (
    .clk(clk), .rst(rst), .i_en(i_hr_en), .i_up(i_up), .o_cnt(w_hours)
  );
  binaryCounter #(.WIDTH(MINS_W), .MOD(MINS_MOD)) u_minutes (
    .clk(clk), .rst(rst), .i_en(i_min_en), .i_up(i_up), .o_cnt(w_minutes)
  );

  assign w_match = i_alarm_en && (i_cur_hours == w_hours) && (i_cur_minutes == w_minutes);

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_TICKS = SNOOZE_MINS * 60;
  localparam int SZ_W      = $clog2(SNZ_TICKS + 1);
  logic [SZ_W-1:0] r_snz_cnt, w_snz_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_snz_cnt <= '0;
    else     r_snz_cnt <= w_snz_cnt_nxt;
  end
`else
  logic w_unused_snooze;
  assign w_unused_snooze = i_snooze;
`endif

  // Reset holds match_q high so an alarm already matching at reset stays silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_q    <= 1'b1;
      r_state      <= ST_IDLE;
      r_ring_timer <= '0;
    end else begin
      r_match_q    <= w_match;
      r_state      <= w_state_nxt;
      r_ring_timer <= w_ring_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ring_timer_nxt = r_ring_timer;
`ifdef ALARM_SNOOZE_EN
    w_snz_cnt_nxt    = r_snz_cnt;
`endif
    if (!i_alarm_en) begin
      w_state_nxt      = ST_IDLE;
      w_ring_timer_nxt = '0;
`ifdef ALARM_SNOOZE_EN
      w_snz_cnt_nxt    = '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_match && !r_match_q) begin
            w_state_nxt      = ST_RINGING;
            w_ring_timer_nxt = '0;
          end
        end
        ST_RINGING: begin
          // Dismiss wins over a simultaneous snooze.
          if (i_dismiss) begin
            w_state_nxt      = ST_IDLE;
            w_ring_timer_nxt = '0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (i_snooze) begin
            w_state_nxt      = ST_SNOOZE;
            w_ring_timer_nxt = '0;
            w_snz_cnt_nxt    = SZ_W'(SNZ_TICKS);
          end
`endif
          else if (i_sec_tick) begin
            if (r_ring_timer == RT_W'(RING_SECS - 1)) begin
              w_state_nxt      = ST_IDLE;
              w_ring_timer_nxt = '0;
            end else begin
              w_ring_timer_nxt = r_ring_timer + RT_W'(1);
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (i_dismiss) begin
            w_state_nxt   = ST_IDLE;
            w_snz_cnt_nxt = '0;
          end else if (i_sec_tick) begin
            if (r_snz_cnt <= SZ_W'(1)) begin
              w_state_nxt      = ST_RINGING;
              w_ring_timer_nxt = '0;
              w_snz_cnt_nxt    = '0;
            end else begin
              w_snz_cnt_nxt = r_snz_cnt - SZ_W'(1);
            end
          end
        end
`endif
        default: begin
          w_state_nxt      = ST_IDLE;
          w_ring_timer_nxt = '0;
        end
      endcase
    end
  end

  assign o_hours   = w_hours;
  assign o_minutes = w_minutes;
  assign o_ring    = (r_state == ST_RINGING);
endmodule

// File: rtl/binary_counter.sv
// Modulo-MOD up/down counter stepping by one on each enable; wraps at both ends.
// Synchronous active-high reset to zero.
module binaryCounter #(
  parameter int WIDTH = 5,
  parameter int MOD   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_cnt
);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_up) begin
        r_cnt <= (r_cnt == MAX_VAL) ? '0 : r_cnt + WIDTH'(1);
      end else begin
        r_cnt <= (r_cnt == '0) ? MAX_VAL : r_cnt - WIDTH'(1);
      end
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/alarm_bank.sv
// Bank of NUM_ALARMS alarm channels sharing time, adjust and user inputs.
// Optional snooze support is enabled with the ALARM_SNOOZE_EN macro.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS  = 2,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sec_tick,
  input  logic [HOURS_W-1:0]    cur_hours,
  input  logic [MINS_W-1:0]     cur_minutes,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  hr,
  input  logic                  min,
  input  logic                  updown,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  dismiss,
  input  logic                  snooze,
  output logic [HOURS_W-1:0]    sel_hours,
  output logic [MINS_W-1:0]     sel_minutes,
  output logic [NUM_ALARMS-1:0] ring,
  output logic                  ring_any
);
  logic [HOURS_W-1:0]    w_hours   [NUM_ALARMS];
  logic [MINS_W-1:0]     w_minutes [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] w_ring;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    logic w_sel_hit;
    assign w_sel_hit = (int'(sel) == g);

    alarm_channel #(.RING_SECS(RING_SECS), .SNOOZE_MINS(SNOOZE_MINS)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_sec_tick   (sec_tick),
      .i_cur_hours  (cur_hours),
      .i_cur_minutes(cur_minutes),
      .i_hr_en      (hr && w_sel_hit),
      .i_min_en     (min && w_sel_hit),
      .i_up         (updown),
      .i_alarm_en   (alarm_en[g]),
      .i_dismiss    (dismiss),
      .i_snooze     (snooze),
      .o_hours      (w_hours[g]),
      .o_minutes    (w_minutes[g]),
      .o_ring       (w_ring[g])
    );
  end

  // Out-of-range sel reads as 00:00.
  always_comb begin
    sel_hours   = '0;
    sel_minutes = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (int'(sel) == i) begin
        sel_hours   = w_hours[i];
        sel_minutes = w_minutes[i];
      end
    end
  end

  assign ring     = w_ring;
  assign ring_any = |w_ring;
endmodule
